// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: access sizes, fault codes, FSM states
// and the request fault classifier.
package lsu_pkg;

    typedef enum logic [1:0] {
        SZ_BYTE = 2'd0,
        SZ_HALF = 2'd1,
        SZ_WORD = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        F_NONE     = 2'd0,
        F_MISALIGN = 2'd1,
        F_RANGE    = 2'd2,
        F_SIZE     = 2'd3
    } fault_e;

    typedef enum logic {
        IDLE  = 1'b0,
        MERGE = 1'b1
    } state_e;

    // Illegal size outranks misalignment, which outranks an out-of-range address.
    function automatic fault_e classify_fault(input logic [1:0] size,
                                              input logic [1:0] offset,
                                              input logic       out_of_range);
        fault_e code;
        code = F_NONE;
        if (size == 2'd3) begin
            code = F_SIZE;
        end else if ((size == SZ_HALF && offset[0]) ||
                     (size == SZ_WORD && offset != 2'd0)) begin
            code = F_MISALIGN;
        end else if (out_of_range) begin
            code = F_RANGE;
        end
        return code;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Little-endian lane steering: STORE=0 extracts and extends a load lane,
// STORE=1 merges a byte/half of lane_data into word_in.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter bit STORE = 1'b0
) (
    input  logic [31:0] word_in,
    input  logic [31:0] lane_data,
    input  size_e       size,
    input  logic [1:0]  offset,
    input  logic        is_signed,
    output logic [31:0] word_out
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] loaded;
    logic [31:0] merged;

    always_comb begin
        byte_sel = word_in[{offset, 3'b000} +: 8];
        half_sel = word_in[{offset[1], 4'b0000} +: 16];

        case (size)
            SZ_BYTE: loaded = {{24{is_signed & byte_sel[7]}}, byte_sel};
            SZ_HALF: loaded = {{16{is_signed & half_sel[15]}}, half_sel};
            default: loaded = word_in;
        endcase

        merged = word_in;
        case (size)
            SZ_BYTE: merged[{offset, 3'b000} +: 8]     = lane_data[7:0];
            SZ_HALF: merged[{offset[1], 4'b0000} +: 16] = lane_data[15:0];
            default: merged = lane_data;
        endcase

        word_out = STORE ? merged : loaded;
    end

endmodule

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-addressed data memory;
// sub-word stores become a read cycle followed by a MERGE write cycle.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int unsigned NUM_WORDS = 256,
    parameter int unsigned IDX_W     = $clog2(NUM_WORDS)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        load_valid,
    output logic [31:0] load_data,
    output logic        fault,
    output logic [1:0]  fault_code,
    output logic [31:0] fault_addr,
    output logic [31:0] mem_addr,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata
);

    state_e            state_q, state_d;
    logic              load_valid_q, load_valid_d;
    logic [31:0]       load_data_q, load_data_d;
    logic              fault_q, fault_d;
    fault_e            fault_code_q, fault_code_d;
    logic [31:0]       fault_addr_q, fault_addr_d;
    logic [31:0]       merge_q, merge_d;
    logic [IDX_W-1:0]  idx_q, idx_d;

    logic [IDX_W-1:0]  req_idx;
    fault_e            req_fault;
    logic              accept, do_load, do_store_word, do_store_sub;
    logic [31:0]       load_word, merge_word;

    assign req_idx       = req_addr[IDX_W+1:2];
    assign req_fault     = classify_fault(req_size, req_addr[1:0], |req_addr[31:IDX_W+2]);
    assign req_ready     = rst && (state_q == IDLE);
    assign accept        = req_valid && req_ready;
    assign do_load       = accept && (req_fault == F_NONE) && !req_write;
    assign do_store_word = accept && (req_fault == F_NONE) && req_write && (req_size == SZ_WORD);
    assign do_store_sub  = accept && (req_fault == F_NONE) && req_write && (req_size != SZ_WORD);

    lsu_lane_align #(.STORE(1'b0)) u_load_align (
        .word_in   (mem_rdata),
        .lane_data (req_wdata),
        .size      (size_e'(req_size)),
        .offset    (req_addr[1:0]),
        .is_signed (req_signed),
        .word_out  (load_word)
    );

    lsu_lane_align #(.STORE(1'b1)) u_store_align (
        .word_in   (mem_rdata),
        .lane_data (req_wdata),
        .size      (size_e'(req_size)),
        .offset    (req_addr[1:0]),
        .is_signed (1'b0),
        .word_out  (merge_word)
    );

    // Gating with rst drops a pending MERGE write the moment reset asserts.
    always_comb begin
        mem_read  = rst && (do_load || do_store_sub);
        mem_write = rst && ((state_q == MERGE) || do_store_word);
        mem_addr  = {{(32-IDX_W){1'b0}}, (state_q == MERGE) ? idx_q : req_idx};
        mem_wdata = (state_q == MERGE) ? merge_q : req_wdata;
    end

    always_comb begin
        // NOTE: every _d is defaulted before the case so no path can infer a latch.
        state_d      = state_q;
        load_valid_d = 1'b0;
        load_data_d  = load_data_q;
        fault_d      = 1'b0;
        fault_code_d = fault_code_q;
        fault_addr_d = fault_addr_q;
        merge_d      = merge_q;
        idx_d        = idx_q;

        case (state_q)
            IDLE: begin
                if (accept && req_fault != F_NONE) begin
                    fault_d      = 1'b1;
                    fault_code_d = req_fault;
                    fault_addr_d = req_addr;
                end else if (do_load) begin
                    load_valid_d = 1'b1;
                    load_data_d  = load_word;
                end else if (do_store_sub) begin
                    merge_d = merge_word;
                    idx_d   = req_idx;
                    state_d = MERGE;
                end
            end
            MERGE:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= IDLE;
            load_valid_q <= 1'b0;
            load_data_q  <= '0;
            fault_q      <= 1'b0;
            fault_code_q <= F_NONE;
            fault_addr_q <= '0;
            merge_q      <= '0;
            idx_q        <= '0;
        end else begin
            state_q      <= state_d;
            load_valid_q <= load_valid_d;
            load_data_q  <= load_data_d;
            fault_q      <= fault_d;
            fault_code_q <= fault_code_d;
            fault_addr_q <= fault_addr_d;
            merge_q      <= merge_d;
            idx_q        <= idx_d;
        end
    end

    assign load_valid = load_valid_q;
    assign load_data  = load_data_q;
    assign fault      = fault_q;
    assign fault_code = fault_code_q;
    assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: table-driven requests against a word memory model,
// with load/fault results scoreboarded through queues.
module tb_load_store_unit;

    typedef enum int {K_LOAD, K_FAULT, K_STW, K_STSUB} kind_e;

    typedef struct {
        logic        write;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        kind_e       kind;
        logic [31:0] exp;
        logic [1:0]  code;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [1:0]  req_size = 2'd0;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        load_valid;
    logic [31:0] load_data;
    logic        fault;
    logic [1:0]  fault_code;
    logic [31:0] fault_addr;
    logic [31:0] mem_addr;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;
    int lv_run = 0;
    int lv_max = 0;

    logic [31:0] load_q[$];
    logic [33:0] fault_q[$];
    vec_t        vecs[$];

    logic [31:0] mem [0:255];

    always #5 clk = ~clk;

    assign mem_rdata = (mem_addr[31:8] == 24'd0) ? mem[mem_addr[7:0]] : 32'd0;

    always @(posedge clk) begin
        if (mem_write && mem_addr[31:8] == 24'd0) mem[mem_addr[7:0]] <= mem_wdata;
    end

    load_store_unit dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_write  (req_write),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .load_valid (load_valid),
        .load_data  (load_data),
        .fault      (fault),
        .fault_code (fault_code),
        .fault_addr (fault_addr),
        .mem_addr   (mem_addr),
        .mem_read   (mem_read),
        .mem_write  (mem_write),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Registered outputs are sampled 2 time units after each rising edge.
    always @(posedge clk) begin
        logic [31:0] exp_d;
        logic [33:0] exp_f;
        #2;
        if (load_valid) begin
            lv_run++;
            if (lv_run > lv_max) lv_max = lv_run;
            if (load_q.size() == 0) begin
                check("unexpected load_valid", 32'd1, 32'd0);
            end else begin
                exp_d = load_q.pop_front();
                check("load_data", load_data, exp_d);
            end
        end else begin
            lv_run = 0;
        end
        if (fault) begin
            if (fault_q.size() == 0) begin
                check("unexpected fault", 32'd1, 32'd0);
            end else begin
                exp_f = fault_q.pop_front();
                check("fault_code", {30'd0, fault_code}, {30'd0, exp_f[33:32]});
                check("fault_addr", fault_addr, exp_f[31:0]);
            end
        end
    end

    function automatic vec_t ld(input logic [1:0] size, input logic sgn,
                                input logic [31:0] addr, input logic [31:0] exp);
        vec_t v;
        v = '{write: 1'b0, size: size, sgn: sgn, addr: addr, wdata: 32'd0,
              kind: K_LOAD, exp: exp, code: 2'd0};
        return v;
    endfunction

    function automatic vec_t st(input logic [1:0] size, input logic [31:0] addr,
                                input logic [31:0] wdata, input logic [31:0] exp);
        vec_t v;
        v = '{write: 1'b1, size: size, sgn: 1'b0, addr: addr, wdata: wdata,
              kind: (size == 2'd2) ? K_STW : K_STSUB, exp: exp, code: 2'd0};
        return v;
    endfunction

    function automatic vec_t flt(input logic write, input logic [1:0] size,
                                 input logic [31:0] addr, input logic [1:0] code);
        vec_t v;
        v = '{write: write, size: size, sgn: 1'b1, addr: addr, wdata: 32'hA5A5A5A5,
              kind: K_FAULT, exp: 32'd0, code: code};
        return v;
    endfunction

    task automatic drive(input logic write, input logic [1:0] size, input logic sgn,
                         input logic [31:0] addr, input logic [31:0] wdata);
        req_valid  = 1'b1;
        req_write  = write;
        req_size   = size;
        req_signed = sgn;
        req_addr   = addr;
        req_wdata  = wdata;
    endtask

    task automatic issue(input vec_t v);
        logic [31:0] idx;
        idx = {22'd0, v.addr[9:2]};
        @(negedge clk);
        drive(v.write, v.size, v.sgn, v.addr, v.wdata);
        #1;
        check("accept req_ready", {31'd0, req_ready}, 32'd1);
        case (v.kind)
            K_LOAD: begin
                check("load mem_read", {31'd0, mem_read}, 32'd1);
                check("load mem_write", {31'd0, mem_write}, 32'd0);
                check("load mem_addr", mem_addr, idx);
                load_q.push_back(v.exp);
            end
            K_FAULT: begin
                check("fault mem_read", {31'd0, mem_read}, 32'd0);
                check("fault mem_write", {31'd0, mem_write}, 32'd0);
                fault_q.push_back({v.code, v.addr});
            end
            K_STW: begin
                check("sw mem_write", {31'd0, mem_write}, 32'd1);
                check("sw mem_read", {31'd0, mem_read}, 32'd0);
                check("sw mem_addr", mem_addr, idx);
                check("sw mem_wdata", mem_wdata, v.wdata);
            end
            default: begin
                check("rmw read mem_read", {31'd0, mem_read}, 32'd1);
                check("rmw read mem_write", {31'd0, mem_write}, 32'd0);
                check("rmw read mem_addr", mem_addr, idx);
            end
        endcase
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        if (v.kind == K_STSUB) begin
            check("merge req_ready", {31'd0, req_ready}, 32'd0);
            check("merge mem_write", {31'd0, mem_write}, 32'd1);
            check("merge mem_read", {31'd0, mem_read}, 32'd0);
            check("merge mem_addr", mem_addr, idx);
            check("merge mem_wdata", mem_wdata, v.exp);
            @(negedge clk);
            #1;
            check("after merge req_ready", {31'd0, req_ready}, 32'd1);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        @(negedge clk);
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd0);
        check("reset mem_read", {31'd0, mem_read}, 32'd0);
        check("reset mem_write", {31'd0, mem_write}, 32'd0);
        check("reset load_valid", {31'd0, load_valid}, 32'd0);
        check("reset load_data", load_data, 32'd0);
        check("reset fault", {31'd0, fault}, 32'd0);
        check("reset fault_code", {30'd0, fault_code}, 32'd0);
        check("reset fault_addr", fault_addr, 32'd0);
        @(negedge clk);
        rst = 1'b1;

        vecs.push_back(st(2'd2, 32'h10, 32'hDEADBEEF, 32'h0));
        vecs.push_back(st(2'd2, 32'h20, 32'hCAFEF00D, 32'h0));
        vecs.push_back(st(2'd2, 32'h00, 32'd1, 32'h0));
        vecs.push_back(st(2'd2, 32'h04, 32'd2, 32'h0));
        vecs.push_back(st(2'd2, 32'h08, 32'd3, 32'h0));
        vecs.push_back(ld(2'd2, 1'b0, 32'h10, 32'hDEADBEEF));
        vecs.push_back(ld(2'd0, 1'b1, 32'h13, 32'hFFFFFFDE));
        vecs.push_back(ld(2'd0, 1'b0, 32'h13, 32'h000000DE));
        vecs.push_back(ld(2'd1, 1'b1, 32'h10, 32'hFFFFBEEF));
        vecs.push_back(ld(2'd1, 1'b0, 32'h12, 32'h0000DEAD));
        vecs.push_back(ld(2'd0, 1'b1, 32'h10, 32'hFFFFFFEF));
        vecs.push_back(ld(2'd0, 1'b0, 32'h11, 32'h000000BE));
        vecs.push_back(flt(1'b0, 2'd1, 32'h11, 2'd1));
        vecs.push_back(flt(1'b0, 2'd2, 32'h400, 2'd2));
        vecs.push_back(flt(1'b0, 2'd3, 32'h10, 2'd3));
        vecs.push_back(flt(1'b1, 2'd2, 32'h12, 2'd1));
        vecs.push_back(flt(1'b0, 2'd3, 32'h401, 2'd3));
        vecs.push_back(flt(1'b0, 2'd2, 32'h402, 2'd1));
        vecs.push_back(flt(1'b1, 2'd0, 32'h8000_0000, 2'd2));
        vecs.push_back(st(2'd2, 32'h3FC, 32'h12345678, 32'h0));
        vecs.push_back(ld(2'd2, 1'b0, 32'h3FC, 32'h12345678));
        vecs.push_back(st(2'd2, 32'h0C, 32'h11223344, 32'h0));
        vecs.push_back(st(2'd1, 32'h0E, 32'hFFFFABCD, 32'hABCD3344));
        vecs.push_back(st(2'd0, 32'h0C, 32'h00000099, 32'hABCD3399));
        vecs.push_back(ld(2'd1, 1'b0, 32'h0E, 32'h0000ABCD));
        vecs.push_back(ld(2'd0, 1'b1, 32'h0C, 32'hFFFFFF99));
        vecs.push_back(ld(2'd2, 1'b0, 32'h0C, 32'hABCD3399));

        foreach (vecs[i]) issue(vecs[i]);

        // SB 0x55 to 0x11, with a load held on req_valid through MERGE
        @(negedge clk);
        drive(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000055);
        #1;
        check("sb c0 mem_read", {31'd0, mem_read}, 32'd1);
        check("sb c0 req_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        drive(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        #1;
        check("sb c1 req_ready", {31'd0, req_ready}, 32'd0);
        check("sb c1 mem_write", {31'd0, mem_write}, 32'd1);
        check("sb c1 mem_read", {31'd0, mem_read}, 32'd0);
        check("sb c1 mem_addr", mem_addr, 32'd4);
        check("sb c1 mem_wdata", mem_wdata, 32'hDEAD55EF);
        @(negedge clk);
        #1;
        check("sb c2 req_ready", {31'd0, req_ready}, 32'd1);
        check("sb c2 load mem_read", {31'd0, mem_read}, 32'd1);
        load_q.push_back(32'hDEAD55EF);
        @(negedge clk);
        req_valid = 1'b0;

        // Reset during the MERGE cycle of SH 0x1234 to 0x22
        @(negedge clk);
        drive(1'b1, 2'd1, 1'b0, 32'h22, 32'h00001234);
        #1;
        check("rst-rmw c0 mem_read", {31'd0, mem_read}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        #1;
        check("rst-rmw merge mem_write", {31'd0, mem_write}, 32'd1);
        rst = 1'b0;
        #1;
        check("rst-rmw mem_write dropped", {31'd0, mem_write}, 32'd0);
        check("rst-rmw req_ready low", {31'd0, req_ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst-rmw idle req_ready", {31'd0, req_ready}, 32'd1);
        check("rst-rmw idle mem_write", {31'd0, mem_write}, 32'd0);
        issue(ld(2'd2, 1'b0, 32'h20, 32'hCAFEF00D));

        // Three back-to-back word loads
        lv_max = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            drive(1'b0, 2'd2, 1'b0, 32'(4 * i), 32'h0);
            #1;
            check("b2b mem_read", {31'd0, mem_read}, 32'd1);
            load_q.push_back(32'(i + 1));
        end
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("b2b load_valid run", 32'(lv_max), 32'd3);

        check("load queue drained", 32'(load_q.size()), 32'd0);
        check("fault queue drained", 32'(fault_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Memory-stage front end that sits directly upstream of the word-addressed data memory.
- Converts byte-addressed MIPS load/store requests (LB/LBU/LH/LHU/LW/SB/SH/SW) into word accesses.
- Handles little-endian lane extraction and sign/zero extension, and performs sub-word stores as a 2-cycle read-modify-write, because the memory only writes whole words.
- Flags misaligned and out-of-range accesses instead of issuing them.

Parameters:
- NUM_WORDS, 256, depth of the downstream data memory in 32-bit words.
- IDX_W, 8, word-index width, equal to clog2(NUM_WORDS).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  LSU can accept a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word; 3 is illegal.
- req_signed  in  1  sign-extend load result (LB/LH).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- load_valid  out  1  one-cycle pulse when load_data is valid.
- load_data  out  32  extended load result.
- fault  out  1  one-cycle pulse for a rejected request.
- fault_code  out  2  1 = misaligned, 2 = out of range, 3 = illegal size.
- fault_addr  out  32  req_addr of the faulting request.
- mem_addr  out  32  word index (zero-extended) to the data memory.
- mem_read  out  1  memory read enable.
- mem_write  out  1  memory write enable.
- mem_wdata  out  32  word written to memory.
- mem_rdata  in  32  combinational read data from memory.

Behaviour:
- Reset (rst low, async):
  - state = IDLE, load_valid = 0, load_data = 0, fault = 0, fault_code = 0, fault_addr = 0, merge register = 0.
  - Combinational outputs are forced to mem_read = 0, mem_write = 0, req_ready = 0.
  - Reset mid-RMW abandons the write; no memory write occurs.
- States: IDLE, MERGE.
- req_ready = 1 only in IDLE with rst high. A request is accepted when req_valid && req_ready.
- Word index is req_addr[IDX_W+1:2]. mem_addr = {0, index}.
- Fault check on accept, evaluated in priority order:
  1. req_size == 3 -> code 3.
  2. Misaligned (half with addr[0] = 1; word with addr[1:0] != 0) -> code 1.
  3. req_addr[31:IDX_W+2] != 0 -> code 2.
- Faulting request:
  - No mem_read or mem_write is issued.
  - Next cycle: fault = 1, with fault_code and fault_addr registered.
  - State stays IDLE; load_valid stays 0.
- Load (no fault):
  - mem_read = 1 in the accept cycle.
  - Selected lane is extracted (byte lane = addr[1:0], half lane = addr[1]; byte 0 = bits 7:0), extended, and registered.
  - load_valid = 1 and load_data are presented the next cycle. Latency is 1.
  - load_data holds its value until the next load.
- Word store: mem_write = 1 and mem_wdata = req_wdata in the accept cycle. State stays IDLE.
- Sub-word store:
  - Accept cycle: mem_read = 1. The merge register captures mem_rdata with the target lane replaced by req_wdata[7:0] or req_wdata[15:0]. Index is latched. Next state is MERGE.
  - MERGE cycle: mem_write = 1, mem_addr = latched index, mem_wdata = merge register, req_ready = 0. Next state is IDLE.
  - Throughput is one sub-word store per 2 cycles.
- mem_read and mem_write are never both 1 in the same cycle.
- req_valid while in MERGE is ignored, not accepted.
- Back-to-back loads give one result per cycle.
- fault and load_valid are pulses and self-clear when no new event occurs.

Decomposition:
- Package lsu_pkg:
  - enum for size: SZ_BYTE, SZ_HALF, SZ_WORD.
  - enum for fault codes: F_NONE, F_MISALIGN, F_RANGE, F_SIZE.
  - state enum: IDLE, MERGE.
- Sub-module lsu_lane_align: purely combinational.
  - Load path: extract and sign/zero-extend.
  - Store path: merge a byte or half into a word.
  - Instantiated once for each path.

Test Plan:
- SW to addr 0x10 with 0xDEADBEEF, then LW from 0x10 -> accept cycle shows mem_write = 1, mem_addr = 4; one cycle after the load accept, load_valid = 1 and load_data = 0xDEADBEEF.
- With word 4 = 0xDEADBEEF, LB from 0x13 -> 0xFFFFFFDE; LBU from 0x13 -> 0x000000DE; LH from 0x10 -> 0xFFFFBEEF; LHU from 0x12 -> 0x0000DEAD.
- SB of 0x55 to 0x11 over 0xDEADBEEF -> cycle 0: mem_read = 1 and req_ready = 1. Cycle 1: req_ready = 0, mem_write = 1, mem_wdata = 0xDEAD55EF. Cycle 2: req_ready = 1.
- LH from 0x11 -> next cycle fault = 1, fault_code = 1, fault_addr = 0x11, no memory enables. Address 0x400 -> fault_code = 2. req_size = 3 -> fault_code = 3.
- rst low during the MERGE cycle of SH 0x1234 to 0x22 -> mem_write drops immediately, state = IDLE, and a later LW of 0x20 returns the original word.
- Three back-to-back LWs to 0x0, 0x4, 0x8 holding 1, 2, 3 -> load_valid is high for 3 consecutive cycles with data 1, 2, 3.
